// File: rtl/uart_byte_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver_if
// Bundles the serial input and the byte-side outputs of the UART receiver.
//   rx_serial      : asynchronous serial line, idles high
//   byte_out       : last correctly framed byte, held between strobes
//   byte_available : one-cycle pulse when byte_out updates
//   framing_error  : one-cycle pulse when a stop bit samples low
//   busy           : receiver is inside a frame (any state except idle)
// Modports:
//   master : the receiver (consumes rx_serial, drives the byte-side outputs)
//   slave  : the line driver / byte consumer on the other side
// ---------------------------------------------------------------------------
interface uart_byte_receiver_if;
    logic       rx_serial;
    logic [7:0] byte_out;
    logic       byte_available;
    logic       framing_error;
    logic       busy;

    modport master (
        input  rx_serial,
        output byte_out,
        output byte_available,
        output framing_error,
        output busy
    );

    modport slave (
        output rx_serial,
        input  byte_out,
        input  byte_available,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// uart_byte_receiver
// 8N1 asynchronous serial receiver feeding the command parser. The line is
// synchronised, the start bit is confirmed at mid-bit, eight data bits are
// sampled LSB first one bit time apart, and the stop bit decides between
// publishing the byte (byte_available strobe) and flagging a framing error.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous reset, active-low
//   bus : uart_byte_receiver_if.master (rx_serial in; byte_out,
//         byte_available, framing_error, busy out)
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   HALF_BIT     : cycles from start edge detection to the mid-bit sample
// ---------------------------------------------------------------------------
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_byte_receiver_if.master       bus
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_reg_q, shift_reg_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_available_q, byte_available_d;
    logic        framing_error_q, framing_error_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            // Synchroniser resets to the idle line level so reset release
            // never looks like a start edge.
            rx_meta_q        <= 1'b1;
            rx_s_q           <= 1'b1;
            clk_cnt_q        <= '0;
            bit_idx_q        <= '0;
            shift_reg_q      <= '0;
            byte_out_q       <= '0;
            byte_available_q <= 1'b0;
            framing_error_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            rx_meta_q        <= rx_meta_d;
            rx_s_q           <= rx_s_d;
            clk_cnt_q        <= clk_cnt_d;
            bit_idx_q        <= bit_idx_d;
            shift_reg_q      <= shift_reg_d;
            byte_out_q       <= byte_out_d;
            byte_available_q <= byte_available_d;
            framing_error_q  <= framing_error_d;
        end
    end

    always_comb begin
        rx_meta_d        = bus.rx_serial;
        rx_s_d           = rx_meta_q;
        state_d          = state_q;
        clk_cnt_d        = clk_cnt_q + 16'd1;
        bit_idx_d        = bit_idx_q;
        shift_reg_d      = shift_reg_q;
        byte_out_d       = byte_out_q;
        byte_available_d = 1'b0;
        framing_error_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                // A start bit that is no longer low at mid-bit was a glitch.
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                // Counter restarts at every sample so each data bit is taken
                // one full bit time after the previous mid-bit point.
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d   = '0;
                    shift_reg_d = {rx_s_q, shift_reg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at the stop mid-sample leaves half a bit
                // of slack to catch an immediately following start edge.
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        byte_out_d       = shift_reg_q;
                        byte_available_d = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low (break) line reports one framing error only.
                if (rx_s_q) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    assign bus.byte_out       = byte_out_q;
    assign bus.byte_available = byte_available_q;
    assign bus.framing_error  = framing_error_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_receiver
// Directed and randomized frames driven onto rx_serial; a reference model of
// the byte stream (expected bytes, expected framing errors, last good byte)
// is kept alongside and compared against what the receiver reports.
// ---------------------------------------------------------------------------
module tb_uart_byte_receiver;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_byte_receiver_if bus();

    uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_assert   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         got_err    = 0;
    int         exp_err    = 0;
    int         strobe_cyc = 0;
    int         start_cyc  = 0;
    int         both_bad   = 0;
    int         busy_bad   = 0;
    logic       prev_busy  = 1'b0;
    logic [7:0] model_byte = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Observer: records every strobe and error pulse the receiver produces.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.byte_available === 1'b1) begin
                got_q.push_back(bus.byte_out);
                strobe_cyc = cyc;
                if (bus.busy !== 1'b0 || prev_busy !== 1'b1) busy_bad++;
            end
            if (bus.framing_error === 1'b1) got_err++;
            if (bus.byte_available === 1'b1 && bus.framing_error === 1'b1) both_bad++;
            prev_busy = bus.busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame; the line is left at the stop level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        bus.rx_serial = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx_serial = b[i];
            wait_cycles(CPB);
        end
        bus.rx_serial = stop_bit;
        wait_cycles(CPB);
        if (stop_bit) begin
            exp_q.push_back(b);
            model_byte = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check($sformatf("%s_byte_out", tag), {24'd0, bus.byte_out}, {24'd0, model_byte});
        check($sformatf("%s_ferr_count", tag), got_err, exp_err);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        int         lat;

        // Reset
        rst = 1'b0;
        bus.rx_serial = 1'b1;
        wait_cycles(5);
        check("reset_byte_out", {24'd0, bus.byte_out}, 32'h00);
        check("reset_byte_available", {31'd0, bus.byte_available}, 32'd0);
        check("reset_framing_error", {31'd0, bus.framing_error}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        wait_cycles(4);

        // Single byte with latency measurement
        send_frame(8'h4C, 1'b1);
        wait_cycles(2 * CPB);
        compare_model("single");
        lat = strobe_cyc - start_cyc;
        check("single_latency_window", {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);
        check("single_idle_after", {31'd0, bus.busy}, 32'd0);

        // Back-to-back frames, no idle gap
        send_frame(8'h4C, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h41, 1'b1);
        wait_cycles(2 * CPB);
        compare_model("b2b");

        // Glitch on the line, then a real byte
        bus.rx_serial = 1'b0;
        wait_cycles(5);
        bus.rx_serial = 1'b1;
        wait_cycles(2 * CPB);
        compare_model("glitch");
        check("glitch_busy", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h46, 1'b1);
        wait_cycles(2 * CPB);
        compare_model("after_glitch");

        // Framing error with the line held low, then release
        send_frame(8'h55, 1'b0);
        wait_cycles(40);
        bus.rx_serial = 1'b1;
        wait_cycles(2 * CPB);
        compare_model("ferr");
        send_frame(8'h30, 1'b1);
        wait_cycles(2 * CPB);
        compare_model("after_ferr");

        // Reset during data bit 4 of 0xFF
        bus.rx_serial = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx_serial = 1'b1;
            wait_cycles(CPB);
        end
        bus.rx_serial = 1'b1;
        wait_cycles(CPB / 2);
        check("midframe_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        wait_cycles(3);
        model_byte = 8'h00;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_byte_out", {24'd0, bus.byte_out}, 32'h00);
        rst = 1'b1;
        wait_cycles(2 * CPB);
        compare_model("midrst");
        send_frame(8'h12, 1'b1);
        wait_cycles(2 * CPB);
        compare_model("after_midrst");

        // Randomized frames with random gaps and occasional bad stop bits
        for (int k = 0; k < 12; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rb, rstop);
            if (!rstop) begin
                wait_cycles($urandom_range(0, 30));
                bus.rx_serial = 1'b1;
                wait_cycles(CPB);
            end else begin
                wait_cycles($urandom_range(0, 20));
            end
        end
        wait_cycles(2 * CPB);
        compare_model("random");

        check("strobe_error_overlap", both_bad, 0);
        check("busy_falls_with_strobe", busy_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- 8N1 asynchronous serial receiver that sits directly upstream of the command parser.
- Oversamples the incoming line, validates the start and stop bits, and presents each received byte on byte_out with a one-cycle byte_available strobe.
- byte_out connects to the parser's byte_in; byte_available connects to the parser's byte_available, which the parser edge-detects.
- byte_out holds its value between strobes, so the parser can read it on the cycle after the edge.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
- HALF_BIT, (CLKS_PER_BIT-1)/2, cycle count from the start-bit falling edge to the mid-bit sample (integer divide).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- rx_serial  input  1  asynchronous serial line; idles high.
- byte_out  output  8  last correctly framed byte; held until the next good byte.
- byte_available  output  1  one-cycle pulse when byte_out updates.
- framing_error  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchroniser: two-flop chain on rx_serial; both flops reset to 1. All decisions use the second flop (rx_s). Input-to-decision latency is 2 cycles.
- Counters:
  - clk_cnt is 16 bits. It resets to 0 on every state change and otherwise increments each cycle.
  - bit_idx is 3 bits.
  - shift_reg is 8 bits, filled LSB first: each sample shifts right and rx_s enters bit 7.
- Reset (rst=0) forces: state=IDLE, byte_out=8'h00, byte_available=0, framing_error=0, busy=0, clk_cnt=0, bit_idx=0, shift_reg=0. Reset mid-frame abandons the frame with no strobe.
- byte_available and framing_error default to 0 every cycle. They are never high in the same cycle.
- IDLE: when rx_s==0, go to START.
- START:
  - When clk_cnt==HALF_BIT, sample rx_s.
  - rx_s==0: go to DATA with bit_idx=0.
  - rx_s==1: treat as a glitch and return to IDLE with no output.
- DATA:
  - When clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift_reg.
  - bit_idx<7: increment bit_idx and stay in DATA.
  - bit_idx==7: go to STOP.
- STOP:
  - When clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: byte_out<=shift_reg and byte_available<=1 in the same cycle; go to IDLE.
  - rx_s==0: framing_error<=1, byte_out unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This covers a break condition: a held-low line produces exactly one framing_error, not repeated frames.
- Back-to-back frames: IDLE is re-entered at the stop-bit mid-sample. A new start edge arriving half a bit later must be caught, giving zero dead time.
- Latency: byte_available rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the rx_serial falling edge of the start bit (±1 cycle of synchroniser phase).
- No buffering: each new good byte overwrites byte_out. The consumer must read it before the next strobe, which is at least 10 bit times away.

Test Plan (CLKS_PER_BIT=16):
- Reset: hold rst=0 for 5 cycles with rx_serial=1 -> byte_out=0x00, byte_available=0, framing_error=0, busy=0.
- Single byte: send 0x4C ('L') at 16 clk/bit -> exactly one byte_available pulse, byte_out=0x4C thereafter, busy falls on the same cycle as the strobe; measured latency within ±1 of the formula.
- Back-to-back: send "L", "3", "A" with no idle gap between frames -> three strobes, byte_out sequence 0x4C, 0x33, 0x41, no framing_error.
- Glitch: drive rx_serial low for 5 cycles, then high -> returns to IDLE, no strobe, no error; a following 0x46 is received correctly.
- Framing error: send 0x55 with stop bit=0, hold low for 40 cycles, then release -> one framing_error pulse, no byte_available, byte_out keeps its previous value; a following 0x30 is received correctly.
- Reset mid-frame: assert rst=0 during data bit 4 of 0xFF, release, then send 0x12 -> no strobe for the aborted frame, byte_out=0x12 after the next strobe.
